puf_challenge_engine: RTL and testbench

// - Consumes the 64-bit challenge word assembled from 8 UART bytes; applies it to the arbiter PUF NUM_EVAL times.
// - Majority-votes the PUF response bits and emits one status/response byte toward the UART transmit side.
// - Sits between the UART frame assembler (upstream) and the uart_tx byte path (downstream).

---
 rtl/puf_pkg.sv | 21 ++
 rtl/puf_eval_timer.sv | 22 ++
 rtl/puf_challenge_engine.sv | 118 +++++++++++
 tb/tb_puf_challenge_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge engine.
package puf_pkg;

  localparam int CHAL_W = 64;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] ERR_CODE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    FIRE   = 3'd2,
    WAIT   = 3'd3,
    REPORT = 3'd4
  } state_t;

  // Status byte: majority bit on top, ones count below.
  function automatic logic [BYTE_W-1:0] pack_resp(input logic maj, input logic [6:0] cnt);
    return {maj, cnt};
  endfunction

endpackage

// File: rtl/puf_eval_timer.sv
// Up-counter that restarts from zero on clear and flags when it reaches term.
module puf_eval_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else            count <= count + W'(1);
  end

  assign tc = (count == term);

endmodule

// File: rtl/puf_challenge_engine.sv
// Applies a challenge to the arbiter PUF NUM_EVAL times, majority-votes the
// response bits and hands one status byte to the UART transmit path.
module puf_challenge_engine
  import puf_pkg::*;
#(
  parameter int NUM_EVAL      = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAL_W-1:0] chal_data,
  input  logic              chal_valid,
  output logic              chal_ready,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_start,
  input  logic              puf_done,
  input  logic              puf_resp,
  output logic [BYTE_W-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam int CW    = $clog2(NUM_EVAL + 1);
  localparam int T_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CW-1:0] EVAL_LAST    = CW'(NUM_EVAL);
  localparam logic [CW-1:0] HALF         = CW'(NUM_EVAL / 2);
  localparam logic [TW-1:0] SETTLE_TERM  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_TERM = TW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] eval_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] eval_next;
  logic [CW-1:0] ones_next;
  logic          timer_clear;
  logic [TW-1:0] timer_term;
  logic          timer_tc;

  assign chal_ready = (state == IDLE) & rst_n;
  assign eval_next  = eval_cnt + CW'(1);
  assign ones_next  = ones_cnt + CW'(puf_resp);

  // One timer serves both the settle count and the arbiter timeout; it runs
  // only in SETTLE/WAIT and restarts whenever either phase is (re)entered.
  assign timer_clear = !((state == SETTLE) || (state == WAIT)) ||
                       ((state == WAIT) && puf_done);
  assign timer_term  = (state == SETTLE) ? SETTLE_TERM : TIMEOUT_TERM;

  puf_eval_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .term  (timer_term),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      puf_challenge <= '0;
      puf_start     <= 1'b0;
      resp_data     <= '0;
      resp_valid    <= 1'b0;
      eval_cnt      <= '0;
      ones_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (chal_valid) begin
            puf_challenge <= chal_data;
            eval_cnt      <= '0;
            ones_cnt      <= '0;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_tc) begin
            puf_start <= 1'b1;
            state     <= FIRE;
          end
        end
        FIRE: begin
          puf_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // A done landing on the last timeout cycle still counts.
          if (puf_done) begin
            ones_cnt <= ones_next;
            eval_cnt <= eval_next;
            if (eval_next == EVAL_LAST) begin
              resp_data  <= pack_resp(ones_next > HALF, 7'(ones_next));
              resp_valid <= 1'b1;
              state      <= REPORT;
            end else begin
              state <= SETTLE;
            end
          end else if (timer_tc) begin
            resp_data  <= ERR_CODE;
            resp_valid <= 1'b1;
            state      <= REPORT;
          end
        end
        REPORT: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_engine.sv
// Directed bench for puf_challenge_engine with a cycle-accurate PUF response model.
module tb_puf_challenge_engine;

  localparam int NE = 5;
  localparam int SC = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] chal_data = '0;
  logic        chal_valid = 1'b0;
  logic        chal_ready;
  logic [63:0] puf_challenge;
  logic        puf_start;
  logic        puf_done = 1'b0;
  logic        puf_resp = 1'b0;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready = 1'b1;

  puf_challenge_engine #(.NUM_EVAL(NE), .SETTLE_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .chal_data     (chal_data),
    .chal_valid    (chal_valid),
    .chal_ready    (chal_ready),
    .puf_challenge (puf_challenge),
    .puf_start     (puf_start),
    .puf_done      (puf_done),
    .puf_resp      (puf_resp),
    .resp_data     (resp_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]     chal;
    logic [4:0]      bits;   // bit k = response of evaluation k
    logic [4:0][4:0] dly;    // dly[k] = cycles from start to done for evaluation k
    int              starts;
    logic [7:0]      exp;
  } vec_t;

  vec_t vecs[7];

  int n_cmp = 0;
  int n_bad = 0;

  // PUF model state
  int              cyc = 0;
  int              n_start = 0;
  int              vec_base = 0;
  int              start_cyc[256];
  int              pend = 0;
  int              mk;
  logic            pend_resp = 1'b0;
  bit              puf_en = 1'b0;
  logic [4:0]      cur_bits = '0;
  logic [4:0][4:0] cur_dly = '0;

  // Done is raised dly[k] cycles after the cycle in which puf_start is seen.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      puf_done = 1'b0;
      puf_resp = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          puf_done = 1'b1;
          puf_resp = pend_resp;
        end
      end
      if (puf_start === 1'b1) begin
        mk = n_start - vec_base;
        if (n_start < 256) start_cyc[n_start] = cyc;
        n_start++;
        if (puf_en && mk >= 0 && mk < NE) begin
          pend      = int'(cur_dly[mk]);
          pend_resp = cur_bits[mk];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] c);
    @(negedge clk);
    chal_data  = c;
    chal_valid = 1'b1;
    @(negedge clk);
    chal_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("resp_valid_seen", resp_valid, 1'b1);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (puf_start === 1'b1) break;
    end
    chk("puf_start_seen", puf_start, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int b;
    cur_bits = v.bits;
    cur_dly  = v.dly;
    puf_en   = 1'b1;
    vec_base = n_start;
    b        = n_start;
    send(v.chal);
    chk("busy_after_accept", chal_ready, 1'b0);
    wait_resp(lat);
    chk("resp_data", resp_data, v.exp);
    chk("puf_challenge", puf_challenge, v.chal);
    chk("start_count", n_start - b, v.starts);
    for (int k = 0; k < v.starts - 1; k++)
      chk("start_gap", start_cyc[b+k+1] - start_cyc[b+k], SC + 1 + int'(v.dly[k]));
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 1'b0);
    chk("ready_after_resp", chal_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{chal: 64'hDEADBEEF_01234567, bits: 5'b01011,
                dly: {5'd2, 5'd2, 5'd2, 5'd2, 5'd2}, starts: 5, exp: 8'h83};
    vecs[1] = '{chal: 64'h01234567_89ABCDEF, bits: 5'b00000,
                dly: {5'd2, 5'd2, 5'd2, 5'd2, 5'd2}, starts: 5, exp: 8'h00};
    vecs[2] = '{chal: 64'hFFFFFFFF_FFFFFFFF, bits: 5'b11111,
                dly: {5'd2, 5'd2, 5'd2, 5'd2, 5'd2}, starts: 5, exp: 8'h85};
    vecs[3] = '{chal: 64'hA5A5A5A5_5A5A5A5A, bits: 5'b10001,
                dly: {5'd1, 5'd1, 5'd1, 5'd1, 5'd1}, starts: 5, exp: 8'h02};
    // done coincides with the last timeout cycle of evaluation 2
    vecs[4] = '{chal: 64'h55555555_AAAAAAAA, bits: 5'b11111,
                dly: {5'd2, 5'd2, 5'd16, 5'd2, 5'd2}, starts: 5, exp: 8'h85};
    // evaluation 1 answers one cycle too late
    vecs[5] = '{chal: 64'h0F0F0F0F_F0F0F0F0, bits: 5'b11111,
                dly: {5'd2, 5'd2, 5'd2, 5'd17, 5'd2}, starts: 2, exp: 8'hFF};
    vecs[6] = '{chal: 64'h13579BDF_2468ACE0, bits: 5'b01110,
                dly: {5'd3, 5'd3, 5'd3, 5'd3, 5'd3}, starts: 5, exp: 8'h83};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_puf_challenge", puf_challenge, 64'h0);
    chk("rst_puf_start", puf_start, 1'b0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_chal_ready", chal_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_chal_ready", chal_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // PUF never answers: one launch, error byte 17 cycles after FIRE
    puf_en   = 1'b0;
    vec_base = n_start;
    seen     = n_start;
    send(64'hCAFEF00D_BAADC0DE);
    wait_start();
    wait_resp(lat);
    chk("timeout_latency", lat, 17);
    chk("timeout_resp", resp_data, 8'hFF);
    chk("timeout_starts", n_start - seen, 1);
    @(negedge clk);
    chk("timeout_resp_clear", resp_valid, 1'b0);

    // Back-pressure in REPORT with a competing challenge
    resp_ready = 1'b0;
    puf_en     = 1'b1;
    cur_bits   = 5'b11111;
    cur_dly    = {5'd2, 5'd2, 5'd2, 5'd2, 5'd2};
    vec_base   = n_start;
    send(64'h11111111_22222222);
    wait_resp(lat);
    chal_data  = 64'h99999999_88888888;
    chal_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1'b1);
      chk("hold_resp_data", resp_data, 8'h85);
      chk("hold_chal_ready", chal_ready, 1'b0);
    end
    chk("hold_challenge", puf_challenge, 64'h11111111_22222222);
    chal_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("release_resp_valid", resp_valid, 1'b0);
    chk("release_chal_ready", chal_ready, 1'b1);

    // Reset pulse while waiting on the PUF
    cur_dly  = {5'd3, 5'd3, 5'd3, 5'd3, 5'd3};
    vec_base = n_start;
    send(64'h76543210_FEDCBA98);
    wait_start();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_chal_ready_low", chal_ready, 1'b0);
    chk("midrst_puf_start", puf_start, 1'b0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || puf_start !== 1'b0) seen++;
      if (i == 0) chk("midrst_idle", chal_ready, 1'b1);
    end
    chk("midrst_no_activity", seen, 0);
    chk("midrst_challenge", puf_challenge, 64'h0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
